// File: rtl/mipszy_imem_encoder.sv
// Program loader for the mipszy core: encodes symbolic instructions into MIPS words and streams them into imem.
// Optional zero-fill of the unused tail of imem is enabled with `define MIPSZY_FILL_NOP_EN.
module mipszy_imem_encoder #(
    parameter int unsigned IM_DEPTH = 64,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wd,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IM_DEPTH - 1);

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_BEQ  = 3'd5;

    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_WRITE = 3'd1,
`ifdef MIPSZY_FILL_NOP_EN
        S_FILL  = 3'd2,
`endif
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                last_q, last_d;
    logic                in_ready_q, in_ready_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [31:0]         im_wd_q, im_wd_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [31:0]         enc_word;
    logic                enc_legal;
    logic                full;

    // Instruction encoder; unused fields per format are simply not referenced.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_op)
            OP_LW:   enc_word = {OPC_LW,   in_rs, in_rt, in_imm};
            OP_SW:   enc_word = {OPC_SW,   in_rs, in_rt, in_imm};
            OP_ADDI: enc_word = {OPC_ADDI, in_rs, in_rt, in_imm};
            OP_BEQ:  enc_word = {OPC_BEQ,  in_rs, in_rt, in_imm};
            OP_ADD:  enc_word = {OPC_R, in_rs, in_rt, in_rd, 5'd0, FN_ADD};
            OP_SUB:  enc_word = {OPC_R, in_rs, in_rt, in_rd, 5'd0, FN_SUB};
            default: enc_legal = 1'b0;
        endcase
    end

    assign full = (wptr_q == LAST_ADDR);

    // Next-state logic; output registers are loaded from the state being entered.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        last_d  = last_q;
        im_wd_d = '0;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    if (enc_legal) begin
                        state_d = S_WRITE;
                        last_d  = in_last;
                        im_wd_d = enc_word;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                wptr_d  = wptr_q + ADDR_W'(1);
                count_d = count_q + CNT_W'(1);
                if (last_q || full) begin
`ifdef MIPSZY_FILL_NOP_EN
                    state_d = full ? S_DONE : S_FILL;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef MIPSZY_FILL_NOP_EN
            S_FILL: begin
                wptr_d  = wptr_q + ADDR_W'(1);
                count_d = count_q + CNT_W'(1);
                if (full) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        in_ready_d = (state_d == S_LOAD);
`ifdef MIPSZY_FILL_NOP_EN
        im_we_d    = (state_d == S_WRITE) || (state_d == S_FILL);
`else
        im_we_d    = (state_d == S_WRITE);
`endif
        im_addr_d  = wptr_d;
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            wptr_q     <= '0;
            count_q    <= '0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b1;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wd_q    <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            in_ready_q <= in_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wd_q    <= im_wd_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wd    = im_wd_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;

endmodule

// File: tb/tb_mipszy_imem_encoder.sv
// Scoreboard bench for mipszy_imem_encoder: directed loads, expected imem writes queued and checked by a monitor.
module tb_mipszy_imem_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [15:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        im_we;
    logic [5:0]  im_addr;
    logic [31:0] im_wd;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [6:0]  count;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  n_pushed = 0;
    int  mon_checks = 0;
    int  mon_fail = 0;
    int  exp_addr = 0;
    time acc_time = 0;

    mipszy_imem_encoder #(.IM_DEPTH(64), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_last(in_last), .im_we(im_we), .im_addr(im_addr),
        .im_wd(im_wd), .cpu_hold(cpu_hold), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    // Monitor: every imem write must match the head of the expected queue.
    always @(negedge clk) begin
        if (im_we) begin
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_fail++;
                $display("FAIL unexpected_write: addr=%0d data=%h, required no write", im_addr, im_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (im_addr !== e.addr || im_wd !== e.data) begin
                    mon_fail++;
                    $display("FAIL imem_write: addr=%0d data=%h, required addr=%0d data=%h",
                             im_addr, im_wd, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr = 0;
    endtask

    task automatic push_fill();
`ifdef MIPSZY_FILL_NOP_EN
        while (exp_addr < 64) begin
            exp_q.push_back('{addr: 6'(exp_addr), data: 32'h0});
            exp_addr++;
            n_pushed++;
        end
`endif
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last,
                        input logic hold, input logic [31:0] word, input bit wr);
        int t;
        t = 0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
        end else begin
            if (wr) begin
                exp_q.push_back('{addr: 6'(exp_addr), data: word});
                exp_addr++;
                n_pushed++;
            end
            @(posedge clk);
            acc_time = $time;
            #1;
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    function automatic logic [6:0] exp_cnt(input int words);
`ifdef MIPSZY_FILL_NOP_EN
        exp_cnt = (words > 0) ? 7'd64 : 7'd0;
`else
        exp_cnt = 7'(words);
`endif
    endfunction

    initial begin
        time t0;
        int  seen;

        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_im_we",    32'(im_we),    32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);

        // Single lw with last: write lands one cycle after acceptance.
        send(3'd0, 5'd0, 5'd8, 5'd0, 16'h0004, 1'b1, 1'b0, 32'h8C080004, 1'b1);
        check("lw_latency_we",   32'(im_we),    32'd1);
        check("lw_latency_addr", 32'(im_addr),  32'd0);
        check("lw_latency_wd",   im_wd,         32'h8C080004);
        check("lw_ready_low",    32'(in_ready), 32'd0);
        push_fill();
        wait_done("lw_done");
        check("lw_count", 32'(count), 32'(exp_cnt(1)));
        check("lw_queue_drained", 32'(exp_q.size()), 32'd0);

        // add, sub, beq(last) program.
        do_reset();
        send(3'd3, 5'd8, 5'd9, 5'd10, 16'h0000, 1'b0, 1'b0, 32'h01095020, 1'b1);
        send(3'd4, 5'd8, 5'd9, 5'd10, 16'h0000, 1'b0, 1'b0, 32'h01095022, 1'b1);
        send(3'd5, 5'd8, 5'd9, 5'd0,  16'hFFFF, 1'b1, 1'b0, 32'h1109FFFF, 1'b1);
        check("prog3_hold_in_write", 32'(cpu_hold), 32'd1);
        push_fill();
        wait_done("prog3_done");
        check("prog3_cpu_hold", 32'(cpu_hold), 32'd0);
        check("prog3_count",    32'(count),    32'(exp_cnt(3)));
        check("prog3_queue_drained", 32'(exp_q.size()), 32'd0);

        // addi then sw with in_valid held high throughout.
        do_reset();
        send(3'd2, 5'd0, 5'd8, 5'd0, 16'h0005, 1'b0, 1'b1, 32'h20080005, 1'b1);
        t0 = acc_time;
        send(3'd1, 5'd0, 5'd9, 5'd0, 16'h0008, 1'b1, 1'b0, 32'hAC090008, 1'b1);
        check("stream_accept_gap_cycles", 32'((acc_time - t0) / 10), 32'd2);
        push_fill();
        wait_done("stream_done");
        check("stream_count", 32'(count), 32'(exp_cnt(2)));
        check("stream_queue_drained", 32'(exp_q.size()), 32'd0);

        // 64 words without last: stops at the final address.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            send(3'd2, 5'd0, 5'd8, 5'd0, 16'(i), 1'b0, 1'b0, 32'h20080000 | 32'(i), 1'b1);
        end
        wait_done("full_done");
        check("full_count", 32'(count), 32'd64);
        seen = mon_checks;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("full_in_ready_after", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        check("full_no_extra_writes", 32'(mon_checks), 32'(seen));
        check("full_queue_drained", 32'(exp_q.size()), 32'd0);

        // Illegal op goes to ERR with nothing written.
        do_reset();
        seen = mon_checks;
        send(3'd7, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("err_flag",     32'(err),      32'd1);
        check("err_in_ready", 32'(in_ready), 32'd0);
        check("err_cpu_hold", 32'(cpu_hold), 32'd1);
        check("err_done",     32'(done),     32'd0);
        check("err_count",    32'(count),    32'd0);
        check("err_no_write", 32'(mon_checks), 32'(seen));

        // Reset during a write restarts the load at address 0.
        do_reset();
        send(3'd0, 5'd0, 5'd8, 5'd0, 16'h0004, 1'b0, 1'b0, 32'h8C080004, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_we_cleared", 32'(im_we), 32'd0);
        check("midrst_count",      32'(count), 32'd0);
        rst = 1'b0;
        exp_addr = 0;
        send(3'd2, 5'd0, 5'd8, 5'd0, 16'h0005, 1'b1, 1'b0, 32'h20080005, 1'b1);
        check("midrst_addr0", 32'(im_addr), 32'd0);
        push_fill();
        wait_done("midrst_done");
        check("midrst_final_count", 32'(count), 32'(exp_cnt(1)));

        repeat (2) @(posedge clk);
        check("monitor_fails",  32'(mon_fail),   32'd0);
        check("writes_checked", 32'(mon_checks), 32'(n_pushed));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
